// File: rtl/cp0_regfile.sv
// CP0 register file: BadVAddr, Count, Compare, Status, Cause, EPC, PRId, EBase.
// Ports: clk/rst_n, hw_int, except_req, MTC0 (we/waddr/wsel/wdata), MFC0 (raddr/rsel/rdata), cp0_regs, interrupt_req, timer_int.
package cp0_pkg;
  typedef struct packed {
    logic        valid;
    logic        eret;
    logic [4:0]  code;
    logic [31:0] extra;
    logic [31:0] pc;
    logic        delayslot;
    logic [31:0] except_vec;
  } except_req_t;

  typedef struct packed {
    logic [31:0] badvaddr;
    logic [31:0] count;
    logic [31:0] compare;
    logic [31:0] status;
    logic [31:0] cause;
    logic [31:0] epc;
    logic [31:0] prid;
    logic [31:0] ebase;
  } cp0_regs_t;
endpackage

module cp0_regfile
  import cp0_pkg::*;
#(
  parameter logic [31:0] CPU_ID    = 32'h0000_4220,
  parameter int          COUNT_DIV = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  hw_int,
  input  except_req_t except_req,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [2:0]  wsel,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr,
  input  logic [2:0]  rsel,
  output logic [31:0] rdata,
  output cp0_regs_t   cp0_regs,
  output logic [7:0]  interrupt_req,
  output logic        timer_int
);

  localparam logic [31:0] STATUS_WMASK = 32'h0040_FF07;
  localparam logic [31:0] EBASE_WMASK  = 32'h3FFF_F000;

  logic [31:0] badvaddr;
  logic [31:0] count;
  logic [31:0] compare;
  logic [31:0] status;
  logic [31:0] epc;
  logic [31:0] ebase;
  logic        bd;
  logic        iv;
  logic        ti;
  logic        hw5;
  logic [1:0]  ip_sw;
  logic [4:0]  ip_hw;
  logic [4:0]  exc;
  logic        phase;

  logic [7:0]  ip;
  logic [31:0] cause;
  logic        wr;
  logic        inc;
  logic        cnt_match;
  logic        bva_code;
  logic        unused_vec;

  // except_vec is only meaningful to the fetch redirect, not here
  assign unused_vec = ^except_req.except_vec;

  // exception/ERET commit wins: the whole MTC0 is dropped
  assign wr = we & ~except_req.valid;

  function automatic logic hit(
    input logic [4:0] a, input logic [2:0] s,
    input logic [4:0] ra, input logic [2:0] rs
  );
    return (a == ra) && (s == rs);
  endfunction

  logic w_count, w_compare, w_status;
  logic w_cause, w_epc, w_ebase;
  assign w_count   = wr & hit(waddr, wsel, 5'd9,  3'd0);
  assign w_compare = wr & hit(waddr, wsel, 5'd11, 3'd0);
  assign w_status  = wr & hit(waddr, wsel, 5'd12, 3'd0);
  assign w_cause   = wr & hit(waddr, wsel, 5'd13, 3'd0);
  assign w_epc     = wr & hit(waddr, wsel, 5'd14, 3'd0);
  assign w_ebase   = wr & hit(waddr, wsel, 5'd15, 3'd1);

  // hw_int[5] sample shares IP7 with the sticky timer flag
  assign ip    = {ti | hw5, ip_hw, ip_sw};
  assign cause = {bd, 7'd0, iv, 7'd0, ip, 1'b0, exc, 2'd0};

  assign inc       = (COUNT_DIV == 1) ? 1'b1 : phase;
  assign cnt_match = (count == compare);
  assign bva_code  = except_req.code inside
                     {5'd1, 5'd2, 5'd3, 5'd4, 5'd5};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      badvaddr <= '0;
      count    <= '0;
      compare  <= '0;
      status   <= 32'h0040_0004;
      epc      <= '0;
      ebase    <= 32'h8000_0000;
      bd       <= 1'b0;
      iv       <= 1'b0;
      ti       <= 1'b0;
      hw5      <= 1'b0;
      ip_sw    <= '0;
      ip_hw    <= '0;
      exc      <= '0;
      phase    <= 1'b0;
    end else begin
      ip_hw <= hw_int[4:0];
      hw5   <= hw_int[5];

      // a Count write restarts the divider and eats this tick
      if (w_count) begin
        count <= wdata;
        phase <= 1'b0;
      end else begin
        if (inc) count <= count + 32'd1;
        phase <= (COUNT_DIV == 1) ? 1'b0 : ~phase;
      end

      if (w_compare) begin
        compare <= wdata;
        ti      <= 1'b0;
      end else if (cnt_match) begin
        ti <= 1'b1;
      end

      if (except_req.valid) begin
        if (except_req.eret) begin
          if (status[2]) status[2] <= 1'b0;
          else           status[1] <= 1'b0;
        end else begin
          if (!status[1]) begin
            epc <= except_req.delayslot ?
                   except_req.pc - 32'd4 : except_req.pc;
            bd  <= except_req.delayslot;
          end
          exc       <= except_req.code;
          status[1] <= 1'b1;
          if (bva_code) badvaddr <= except_req.extra;
        end
      end else begin
        if (w_status)
          status <= (status & ~STATUS_WMASK) |
                    (wdata & STATUS_WMASK);
        if (w_cause) begin
          iv    <= wdata[23];
          ip_sw <= wdata[9:8];
        end
        if (w_epc) epc <= wdata;
        if (w_ebase)
          ebase <= (ebase & ~EBASE_WMASK) |
                   (wdata & EBASE_WMASK);
      end
    end
  end

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      hit(raddr, rsel, 5'd8,  3'd0): rdata = badvaddr;
      hit(raddr, rsel, 5'd9,  3'd0): rdata = count;
      hit(raddr, rsel, 5'd11, 3'd0): rdata = compare;
      hit(raddr, rsel, 5'd12, 3'd0): rdata = status;
      hit(raddr, rsel, 5'd13, 3'd0): rdata = cause;
      hit(raddr, rsel, 5'd14, 3'd0): rdata = epc;
      hit(raddr, rsel, 5'd15, 3'd0): rdata = CPU_ID;
      hit(raddr, rsel, 5'd15, 3'd1): rdata = ebase;
      default: rdata = '0;
    endcase
  end

  assign cp0_regs.badvaddr = badvaddr;
  assign cp0_regs.count    = count;
  assign cp0_regs.compare  = compare;
  assign cp0_regs.status   = status;
  assign cp0_regs.cause    = cause;
  assign cp0_regs.epc      = epc;
  assign cp0_regs.prid     = CPU_ID;
  assign cp0_regs.ebase    = ebase;

  assign interrupt_req = ip & status[15:8];
  assign timer_int     = ip[7];

endmodule

// File: tb/tb_cp0_regfile.sv
// Directed bench for cp0_regfile.
// Drives MTC0/except_req/hw_int vectors and checks hand-computed register values.
module tb_cp0_regfile;
  import cp0_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  hw_int;
  except_req_t ex;
  logic        we;
  logic [4:0]  waddr;
  logic [2:0]  wsel;
  logic [31:0] wdata;
  logic [4:0]  raddr;
  logic [2:0]  rsel;
  logic [31:0] rdata;
  cp0_regs_t   regs;
  logic [7:0]  interrupt_req;
  logic        timer_int;

  int n_tests = 0;
  int n_fail  = 0;

  cp0_regfile dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .hw_int        (hw_int),
    .except_req    (ex),
    .we            (we),
    .waddr         (waddr),
    .wsel          (wsel),
    .wdata         (wdata),
    .raddr         (raddr),
    .rsel          (rsel),
    .rdata         (rdata),
    .cp0_regs      (regs),
    .interrupt_req (interrupt_req),
    .timer_int     (timer_int)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mtc0(input logic [4:0] a,
                      input logic [2:0] s,
                      input logic [31:0] d);
    we = 1'b1; waddr = a; wsel = s; wdata = d;
    tick();
    we = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a,
                    input logic [2:0] s,
                    output logic [31:0] v);
    raddr = a; rsel = s;
    #1;
    v = rdata;
  endtask

  task automatic exc(input logic [4:0] code,
                     input logic [31:0] pc,
                     input logic ds,
                     input logic [31:0] extra);
    ex = '0;
    ex.valid = 1'b1; ex.code = code;
    ex.pc = pc; ex.delayslot = ds; ex.extra = extra;
    tick();
    ex = '0;
  endtask

  task automatic eret();
    ex = '0;
    ex.valid = 1'b1; ex.eret = 1'b1;
    tick();
    ex = '0;
  endtask

  logic [31:0] v;

  initial begin
    rst_n = 1'b0; hw_int = '0; ex = '0;
    we = 1'b0; waddr = '0; wsel = '0; wdata = '0;
    raddr = '0; rsel = '0;

    repeat (2) tick();
    chk("rst_status", regs.status, 32'h0040_0004);
    chk("rst_ebase", regs.ebase, 32'h8000_0000);
    chk("rst_count", regs.count, 32'd0);
    chk("rst_irq", {24'd0, interrupt_req}, 32'd0);
    chk("rst_timer", {31'd0, timer_int}, 32'd0);

    rst_n = 1'b1;
    repeat (10) tick();
    chk("idle_count", regs.count, 32'd5);
    chk("idle_status", regs.status, 32'h0040_0004);
    chk("idle_irq", {24'd0, interrupt_req}, 32'd0);

    mtc0(5'd12, 3'd0, 32'hFFFF_FFFF);
    rd(5'd12, 3'd0, v);
    chk("status_mask", v, 32'h0040_FF07);
    rd(5'd15, 3'd0, v);
    chk("prid", v, 32'h0000_4220);
    rd(5'd0, 3'd0, v);
    chk("unimpl_rd", v, 32'd0);
    mtc0(5'd8, 3'd0, 32'h55);
    rd(5'd8, 3'd0, v);
    chk("bva_ro", v, 32'd0);
    mtc0(5'd15, 3'd1, 32'hFFFF_FFFF);
    rd(5'd15, 3'd1, v);
    chk("ebase_mask", v, 32'hBFFF_F000);

    mtc0(5'd12, 3'd0, 32'h0040_FF05);
    exc(5'd4, 32'hBFC0_0100, 1'b1, 32'h1234);
    chk("exc1_epc", regs.epc, 32'hBFC0_00FC);
    chk("exc1_bd", {31'd0, regs.cause[31]}, 32'd1);
    chk("exc1_code", {27'd0, regs.cause[6:2]}, 32'd4);
    chk("exc1_bva", regs.badvaddr, 32'h1234);
    chk("exc1_status", regs.status, 32'h0040_FF07);

    exc(5'd8, 32'h8000_0000, 1'b0, 32'hFFFF);
    chk("exc2_epc", regs.epc, 32'hBFC0_00FC);
    chk("exc2_code", {27'd0, regs.cause[6:2]}, 32'd8);
    chk("exc2_bd", {31'd0, regs.cause[31]}, 32'd1);
    chk("exc2_bva", regs.badvaddr, 32'h1234);

    eret();
    chk("eret1", regs.status, 32'h0040_FF03);
    eret();
    chk("eret2", regs.status, 32'h0040_FF01);
    chk("eret_epc", regs.epc, 32'hBFC0_00FC);

    mtc0(5'd9, 3'd0, 32'd10);
    mtc0(5'd11, 3'd0, 32'd20);
    chk("tmr_clr", {31'd0, timer_int}, 32'd0);
    chk("tmr_cnt0", regs.count, 32'd10);
    repeat (19) tick();
    chk("tmr_cnt20", regs.count, 32'd20);
    chk("tmr_early", {31'd0, timer_int}, 32'd0);
    tick();
    chk("tmr_set", {31'd0, timer_int}, 32'd1);
    chk("tmr_irq", {24'd0, interrupt_req}, 32'h80);
    mtc0(5'd12, 3'd0, 32'h0040_7F01);
    chk("tmr_masked", {24'd0, interrupt_req}, 32'd0);
    chk("tmr_sticky", {31'd0, timer_int}, 32'd1);
    mtc0(5'd11, 3'd0, 32'd1000);
    chk("tmr_cmp_clr", {31'd0, timer_int}, 32'd0);

    we = 1'b1; waddr = 5'd14; wsel = 3'd0;
    wdata = 32'hDEAD_BEEF;
    exc(5'd0, 32'h0000_0100, 1'b0, 32'd0);
    we = 1'b0;
    chk("prio_epc", regs.epc, 32'h0000_0100);
    chk("prio_status", regs.status, 32'h0040_7F03);

    hw_int = 6'b000101;
    mtc0(5'd12, 3'd0, 32'h0040_FF00);
    chk("hw_irq", {24'd0, interrupt_req}, 32'h14);
    hw_int = 6'b000000;
    tick();
    chk("hw_drop", {24'd0, interrupt_req}, 32'd0);
    hw_int = 6'b100000;
    tick();
    chk("hw5_irq", {24'd0, interrupt_req}, 32'h80);
    hw_int = 6'b000000;
    tick();
    chk("hw5_drop", {31'd0, timer_int}, 32'd0);

    mtc0(5'd13, 3'd0, 32'hFFFF_FFFF);
    rd(5'd13, 3'd0, v);
    chk("cause_mask", v, 32'h0080_0300);
    chk("sw_irq", {24'd0, interrupt_req}, 32'h03);

    ex = '0;
    ex.valid = 1'b1; ex.pc = 32'h200;
    rst_n = 1'b0;
    tick();
    ex = '0;
    chk("mrst_status", regs.status, 32'h0040_0004);
    chk("mrst_epc", regs.epc, 32'd0);
    chk("mrst_cause", regs.cause, 32'd0);
    chk("mrst_count", regs.count, 32'd0);
    chk("mrst_irq", {24'd0, interrupt_req}, 32'd0);
    rst_n = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
